edge_bmp_writer: RTL and testbench

Serializes the 1-bit-per-pixel edge bitmap produced by the Sobel stage into a byte stream laid out as a Windows BMP pixel array (bottom-up rows, MSB-first packing, rows padded to 4 bytes). It sits directly downstream of the edge detector and feeds file/UART/memory sinks through a valid/ready byte interface. It can optionally prepend a complete 62-byte monochrome BMP header.

---
 rtl/edge_bmp_writer.sv | 246 ++++++++++++++++++++++++
 tb/tb_edge_bmp_writer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/edge_bmp_writer.sv
`timescale 1ns/1ps
// edge_bmp_writer: serializes a 1-bpp edge bitmap as a BMP pixel array (optionally with a 62-byte header).
// Latency: start sampled at edge N -> busy after N, first byte valid after N+1; then 1 byte/cycle.
// Backpressure: out_valid/out_ready; out_data/out_last held while stalled, done pulses after the final transfer.
//
// Ports: clk, rst (sync, active-high), start, bitmap[WIDTH*DEPTH:0] (MSB unused),
//        out_data[7:0], out_valid, out_ready, out_last, busy, done.
// Optional feature: define BMP_HEADER_EN to prepend the monochrome BMP header (file + info + palette).

module edge_bmp_writer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH*DEPTH:0] bitmap,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int NPIX      = WIDTH * DEPTH;
    localparam int ROW_BYTES = ((WIDTH + 31) / 32) * 4;
    localparam int PIX_BYTES = ROW_BYTES * DEPTH;
    localparam int CW        = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
    localparam int RW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW        = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(ROW_BYTES - 1);
    localparam logic [RW-1:0] ROW_TOP  = RW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_PIXELS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q;
    logic [NPIX-1:0] snap_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [7:0]      out_data_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            busy_q;
    logic            done_q;

    // The top bit of the bitmap port carries no pixel.
    logic unused_bitmap_msb;
    assign unused_bitmap_msb = bitmap[NPIX];

    // One output byte of the pixel array: bit 7-j holds pixel X = 8*col + j of
    // image row `row`; columns past the image width are padding zeros.
    function automatic logic [7:0] pix_byte(input logic [RW-1:0] row,
                                            input logic [CW-1:0] col,
                                            input logic [NPIX-1:0] img);
        logic [7:0]    b;
        logic [IW-1:0] idx;
        logic          bitv;
        int            x;
        b = 8'h00;
        for (int j = 0; j < 8; j++) begin
            x    = int'(col) * 8 + j;
            bitv = 1'b0;
            if (x < WIDTH) begin
                idx  = IW'(int'(row) * WIDTH + x);
                bitv = img[idx];
            end
            b = {b[6:0], bitv};
        end
        return b;
    endfunction

`ifdef BMP_HEADER_EN
    localparam logic [31:0] FILE_SZ = 32'(62 + PIX_BYTES);
    localparam logic [31:0] IMG_SZ  = 32'(PIX_BYTES);
    localparam logic [31:0] W32     = 32'(WIDTH);
    localparam logic [31:0] H32     = 32'(DEPTH);
    localparam logic [5:0]  HDR_LAST = 6'd61;

    logic [5:0] hdr_q;

    // Header ROM; every byte not listed is zero. All fields little-endian,
    // height positive so the reader treats the pixel rows as bottom-up.
    function automatic logic [7:0] hdr_byte(input logic [5:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            6'd0:  b = 8'h42;            // 'B'
            6'd1:  b = 8'h4D;            // 'M'
            6'd2:  b = FILE_SZ[7:0];
            6'd3:  b = FILE_SZ[15:8];
            6'd4:  b = FILE_SZ[23:16];
            6'd5:  b = FILE_SZ[31:24];
            6'd10: b = 8'd62;            // pixel data offset
            6'd14: b = 8'd40;            // info header size
            6'd18: b = W32[7:0];
            6'd19: b = W32[15:8];
            6'd20: b = W32[23:16];
            6'd21: b = W32[31:24];
            6'd22: b = H32[7:0];
            6'd23: b = H32[15:8];
            6'd24: b = H32[23:16];
            6'd25: b = H32[31:24];
            6'd26: b = 8'd1;             // planes
            6'd28: b = 8'd1;             // bits per pixel
            6'd34: b = IMG_SZ[7:0];
            6'd35: b = IMG_SZ[15:8];
            6'd36: b = IMG_SZ[23:16];
            6'd37: b = IMG_SZ[31:24];
            6'd38: b = 8'h13;            // 2835 pixels/metre
            6'd39: b = 8'h0B;
            6'd42: b = 8'h13;
            6'd43: b = 8'h0B;
            6'd46: b = 8'd2;             // colours used
            6'd58: b = 8'hFF;            // palette entry 1 = white
            6'd59: b = 8'hFF;
            6'd60: b = 8'hFF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction
`endif

    // Position and contents of the byte to present next. Counters always hold
    // the position of the byte currently on out_data; when that byte is
    // accepted, the successor position is computed here and loaded directly.
    logic [RW-1:0] sel_row;
    logic [CW-1:0] sel_col;
    logic          sel_in_hdr;
    logic [7:0]    sel_byte;
    logic          sel_last;
`ifdef BMP_HEADER_EN
    logic [5:0]    sel_hdr;
`endif

    always_comb begin
        sel_row    = row_q;
        sel_col    = col_q;
`ifdef BMP_HEADER_EN
        sel_hdr    = hdr_q;
        sel_in_hdr = (state_q == S_HEADER);
        if (out_valid_q && (state_q == S_HEADER)) begin
            if (hdr_q == HDR_LAST) begin
                sel_in_hdr = 1'b0;
                sel_row    = ROW_TOP;
                sel_col    = '0;
            end else begin
                sel_hdr = hdr_q + 6'd1;
            end
        end else if (out_valid_q) begin
`else
        sel_in_hdr = 1'b0;
        if (out_valid_q) begin
`endif
            if (col_q == COL_LAST) begin
                sel_col = '0;
                sel_row = row_q - 1'b1;
            end else begin
                sel_col = col_q + 1'b1;
            end
        end
`ifdef BMP_HEADER_EN
        sel_byte = sel_in_hdr ? hdr_byte(sel_hdr) : pix_byte(sel_row, sel_col, snap_q);
`else
        sel_byte = pix_byte(sel_row, sel_col, snap_q);
`endif
        sel_last = !sel_in_hdr && (sel_row == '0) && (sel_col == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            snap_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef BMP_HEADER_EN
            hdr_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        snap_q <= bitmap[NPIX-1:0];
                        row_q  <= ROW_TOP;
                        col_q  <= '0;
                        busy_q <= 1'b1;
`ifdef BMP_HEADER_EN
                        hdr_q   <= '0;
                        state_q <= S_HEADER;
`else
                        state_q <= S_PIXELS;
`endif
                    end
                end
                S_HEADER, S_PIXELS: begin
                    // Load a new byte when the output register is empty or
                    // its byte is being accepted this edge.
                    if (!out_valid_q || out_ready) begin
                        if (out_valid_q && out_last_q) begin
                            out_data_q  <= 8'h00;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            out_data_q  <= sel_byte;
                            out_valid_q <= 1'b1;
                            out_last_q  <= sel_last;
                            row_q       <= sel_row;
                            col_q       <= sel_col;
`ifdef BMP_HEADER_EN
                            hdr_q       <= sel_hdr;
`endif
                            state_q     <= sel_in_hdr ? S_HEADER : S_PIXELS;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_edge_bmp_writer.sv
`timescale 1ns/1ps
module tb_edge_bmp_writer;

`ifdef BMP_HEADER_EN
    localparam int HDR = 62;
`else
    localparam int HDR = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // 8x2 instance
    logic        start_a;
    logic [16:0] bitmap_a;
    logic [7:0]  data_a;
    logic        valid_a, ready_a, last_a, busy_a, done_a;
    // 10x1 instance
    logic        start_b;
    logic [10:0] bitmap_b;
    logic [7:0]  data_b;
    logic        valid_b, ready_b, last_b, busy_b, done_b;

    edge_bmp_writer #(.WIDTH(8), .DEPTH(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bitmap(bitmap_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_last(last_a), .busy(busy_a), .done(done_a)
    );

    edge_bmp_writer #(.WIDTH(10), .DEPTH(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bitmap(bitmap_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_last(last_b), .busy(busy_b), .done(done_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    // Runs one image through instance A and checks every transfer.
    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
    // mid_start: pulse start with a different bitmap once 3 bytes are out.
    // abort_at > 0: assert rst after that many transfers and check the abort.
    task automatic run_a(input int mode, input bit mid_start, input int abort_at);
        int idx;
        int total;
        bit pv, pr, pl;
        logic [7:0] pd;
        total = exp_a.size();
        idx = 0;
        start_a = 1'b1;
        ready_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("valid_gap", valid_a, 0);
        chk("busy_after_start", busy_a, 1);
        pv = valid_a; pd = data_a; pl = last_a;
        ready_a = 1'b1;
        pr = ready_a;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0;
                chk("abort_valid", valid_a, 0);
                chk("abort_busy", busy_a, 0);
                chk("abort_last", last_a, 0);
                chk("abort_done", done_a, 0);
                return;
            end
            if (pv && pr) begin
                chk("byte", pd, exp_a[idx]);
                chk("last", pl, (idx == total - 1));
                idx++;
                if (idx == total) begin
                    chk("done_pulse", done_a, 1);
                    chk("valid_after_last", valid_a, 0);
                    chk("busy_after_last", busy_a, 0);
                    return;
                end
            end else if (pv && !pr) begin
                chk("stall_valid", valid_a, 1);
                chk("stall_data", data_a, pd);
                chk("stall_last", last_a, pl);
            end
            pv = valid_a; pd = data_a; pl = last_a;
            ready_a = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            pr = ready_a;
            if (mid_start && idx == 3) begin
                start_a  = 1'b1;
                bitmap_a = 17'h0FF00;
            end else begin
                start_a = 1'b0;
            end
            if (abort_at > 0 && idx == abort_at) rst = 1'b1;
        end
        chk("timeout_bytes", idx, total);
    endtask

    initial begin
        logic [8*62-1:0] hdr_tbl;
        int idx_b;
        rst = 1'b1;
        start_a = 1'b0; ready_a = 1'b0; bitmap_a = 17'h00281;  // bits 0,7,9
        start_b = 1'b0; ready_b = 1'b1; bitmap_b = 11'h301;    // bits 0,8,9
        hdr_tbl = 496'h424D4600_00000000_00003E00_00002800_00000800_00000200_00000100_01000000_00000800_0000130B_0000130B_00000200_00000000_00000000_0000FFFF_FF00;
        if (HDR > 0) begin
            for (int i = 0; i < HDR; i++) exp_a.push_back(hdr_tbl[8*(61-i) +: 8]);
        end
        exp_a.push_back(8'h40); exp_a.push_back(8'h00); exp_a.push_back(8'h00); exp_a.push_back(8'h00);
        exp_a.push_back(8'h81); exp_a.push_back(8'h00); exp_a.push_back(8'h00); exp_a.push_back(8'h00);
        exp_b.push_back(8'h80); exp_b.push_back(8'hC0); exp_b.push_back(8'h00); exp_b.push_back(8'h00);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_last", last_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain stream; then a start during the DONE cycle must be ignored.
        run_a(0, 1'b0, 0);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("start_in_done_ignored", busy_a, 0);
        repeat (2) @(posedge clk);
        #1;

        // Stalling sink.
        run_a(1, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Restart attempt mid-stream with a different bitmap.
        run_a(0, 1'b1, 0);
        bitmap_a = 17'h00281;
        repeat (2) @(posedge clk);
        #1;

        // Reset after the third transfer, then a fresh full stream.
        run_a(0, 1'b0, 3);
        repeat (2) @(posedge clk);
        #1;
        run_a(0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;

        // 10-pixel-wide row: padding bits and bytes must be zero.
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        idx_b = 0;
        for (int k = 0; k < 200; k++) begin
            if (valid_b) begin
                if (idx_b >= HDR) begin
                    chk("b_byte", data_b, exp_b[idx_b - HDR]);
                    chk("b_last", last_b, (idx_b == HDR + 3));
                end
                idx_b++;
                if (last_b) break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("b_done", done_b, 1);
        chk("b_count", idx_b, HDR + 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
